// File: rtl/mvp_pll_vco_seq.sv
// mvp_pll_vco_seq: break-before-make VCO channel switch sequencer (gate old, reset new, wait lock, enable).
// Define MVP_PLL_VCO_SEQ_TIMEOUT_EN to bound the lock wait by TIMEOUT_CYC cycles.
module mvp_pll_vco_seq #(
  parameter int NUM_VCO     = 3,
  parameter int SEL_W       = 2,
  parameter int OFF_CYC     = 8,
  parameter int RST_CYC     = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               switch_req,
  input  logic [SEL_W-1:0]   switch_sel,
  input  logic [NUM_VCO-1:0] vco_lock,
  output logic [NUM_VCO-1:0] vco_clk_en,
  output logic [NUM_VCO-1:0] vco_reset,
  output logic [SEL_W-1:0]   active_sel,
  output logic               active_vld,
  output logic               busy,
  output logic               switch_ack,
  output logic               switch_err,
  output logic               lock_lost
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GATE = 3'd1,
    ST_RST  = 3'd2,
    ST_LOCK = 3'd3,
    ST_EN   = 3'd4
  } state_t;

  localparam logic [15:0]  OFF_LOAD  = 16'(OFF_CYC - 1);
  localparam logic [15:0]  RST_LOAD  = 16'(RST_CYC - 1);
  localparam logic [15:0]  LOCK_LOAD = 16'(TIMEOUT_CYC - 1);
  localparam logic [SEL_W:0] NUM_VCO_W = (SEL_W + 1)'(NUM_VCO);

  state_t             state_r, state_s;
  logic [15:0]        cnt_r, cnt_s;
  logic               arm_r, arm_s;
  logic [SEL_W-1:0]   new_sel_r, new_sel_s;
  logic [SEL_W-1:0]   old_sel_r, old_sel_s;
  logic [NUM_VCO-1:0] clk_en_s, reset_s;
  logic [SEL_W-1:0]   act_sel_s;
  logic               act_vld_s, busy_s, ack_s, err_s, lost_s;
  logic               sel_bad_s;

  assign sel_bad_s = ({1'b0, switch_sel} >= NUM_VCO_W);

  // Next-state and next-output computation for the switch sequence
  always_comb begin
    state_s   = state_r;
    cnt_s     = (cnt_r != 16'd0) ? (cnt_r - 16'd1) : 16'd0;
    arm_s     = arm_r | ~switch_req;
    new_sel_s = new_sel_r;
    old_sel_s = old_sel_r;
    clk_en_s  = vco_clk_en;
    reset_s   = vco_reset;
    act_sel_s = active_sel;
    act_vld_s = active_vld;
    ack_s     = 1'b0;
    err_s     = switch_err;
    lost_s    = lock_lost;
    case (state_r)
      ST_IDLE: begin
        cnt_s = 16'd0;
        if (switch_req && arm_r) begin
          arm_s     = 1'b0;
          err_s     = 1'b0;
          lost_s    = 1'b0;
          new_sel_s = switch_sel;
          if (sel_bad_s) begin
            ack_s = 1'b1;
            err_s = 1'b1;
          end else if (active_vld && (switch_sel == active_sel)) begin
            ack_s = 1'b1;
          end else if (active_vld) begin
            // Break before make: gate the old channel first, reset it later
            state_s              = ST_GATE;
            cnt_s                = OFF_LOAD;
            old_sel_s            = active_sel;
            clk_en_s[active_sel] = 1'b0;
            act_vld_s            = 1'b0;
          end else begin
            state_s             = ST_RST;
            cnt_s               = RST_LOAD;
            reset_s[switch_sel] = 1'b1;
          end
        end else if (active_vld && !vco_lock[active_sel]) begin
          lost_s = 1'b1;
        end else begin
          lost_s = lock_lost;
        end
      end
      ST_GATE: begin
        if (cnt_r == 16'd0) begin
          state_s            = ST_RST;
          cnt_s              = RST_LOAD;
          reset_s[old_sel_r] = 1'b1;
          reset_s[new_sel_r] = 1'b1;
        end else begin
          state_s = ST_GATE;
        end
      end
      ST_RST: begin
        if (cnt_r == 16'd0) begin
          state_s            = ST_LOCK;
          cnt_s              = LOCK_LOAD;
          reset_s[new_sel_r] = 1'b0;
        end else begin
          state_s = ST_RST;
        end
      end
      ST_LOCK: begin
        if (vco_lock[new_sel_r]) begin
          state_s             = ST_EN;
          cnt_s               = 16'd0;
          clk_en_s[new_sel_r] = 1'b1;
          act_sel_s           = new_sel_r;
          act_vld_s           = 1'b1;
          ack_s               = 1'b1;
`ifdef MVP_PLL_VCO_SEQ_TIMEOUT_EN
        end else if (cnt_r == 16'd0) begin
          state_s            = ST_IDLE;
          reset_s[new_sel_r] = 1'b1;
          act_vld_s          = 1'b0;
          ack_s              = 1'b1;
          err_s              = 1'b1;
`endif
        end else begin
          state_s = ST_LOCK;
        end
      end
      ST_EN: begin
        state_s = ST_IDLE;
        cnt_s   = 16'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 16'd0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      arm_r      <= 1'b0;
      new_sel_r  <= '0;
      old_sel_r  <= '0;
      vco_clk_en <= '0;
      vco_reset  <= '1;
      active_sel <= '0;
      active_vld <= 1'b0;
      busy       <= 1'b0;
      switch_ack <= 1'b0;
      switch_err <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      arm_r      <= arm_s;
      new_sel_r  <= new_sel_s;
      old_sel_r  <= old_sel_s;
      vco_clk_en <= clk_en_s;
      vco_reset  <= reset_s;
      active_sel <= act_sel_s;
      active_vld <= act_vld_s;
      busy       <= busy_s;
      switch_ack <= ack_s;
      switch_err <= err_s;
      lock_lost  <= lost_s;
    end
  end

endmodule

// File: tb/tb_mvp_pll_vco_seq.sv
// Directed, table-driven bench for mvp_pll_vco_seq (NUM_VCO=3, OFF_CYC=8, RST_CYC=16, TIMEOUT_CYC=32).
module tb_mvp_pll_vco_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       switch_req;
  logic [1:0] switch_sel;
  logic [2:0] vco_lock;
  logic [2:0] vco_clk_en, vco_reset;
  logic [1:0] active_sel;
  logic       active_vld, busy, switch_ack, switch_err, lock_lost;

  int n_cmp = 0;
  int n_err = 0;

  mvp_pll_vco_seq #(
    .NUM_VCO(3), .SEL_W(2), .OFF_CYC(8), .RST_CYC(16), .TIMEOUT_CYC(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .switch_req(switch_req), .switch_sel(switch_sel),
    .vco_lock(vco_lock), .vco_clk_en(vco_clk_en), .vco_reset(vco_reset),
    .active_sel(active_sel), .active_vld(active_vld), .busy(busy),
    .switch_ack(switch_ack), .switch_err(switch_err), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    int         lat;
    logic [2:0] en;
    logic [2:0] rst;
    logic [1:0] asel;
    logic       vld;
    logic       err;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ack(input int max, output int lat);
    lat = -1;
    for (int c = 1; c <= max; c++) begin
      step();
      if (switch_ack) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks;
    int busy_seen;
    logic [2:0] e_rst, e_en;

    vecs[0] = '{2'd1, 18, 3'b010, 3'b101, 2'd1, 1'b1, 1'b0};
    vecs[1] = '{2'd2, 26, 3'b100, 3'b011, 2'd2, 1'b1, 1'b0};
    vecs[2] = '{2'd3,  1, 3'b100, 3'b011, 2'd2, 1'b1, 1'b1};
    vecs[3] = '{2'd2,  1, 3'b100, 3'b011, 2'd2, 1'b1, 1'b0};
    vecs[4] = '{2'd0, 26, 3'b001, 3'b110, 2'd0, 1'b1, 1'b0};

    reset_n    = 1'b0;
    switch_req = 1'b0;
    switch_sel = 2'd0;
    vco_lock   = 3'b111;
    repeat (3) step();
    chk("rst_en",   32'(vco_clk_en), 32'h0);
    chk("rst_vrst", 32'(vco_reset),  32'h7);
    chk("rst_asel", 32'(active_sel), 32'h0);
    chk("rst_vld",  32'(active_vld), 32'h0);
    chk("rst_busy", 32'(busy),       32'h0);
    chk("rst_ack",  32'(switch_ack), 32'h0);
    chk("rst_err",  32'(switch_err), 32'h0);
    chk("rst_lost", 32'(lock_lost),  32'h0);
    reset_n = 1'b1;
    step();

    // Table: one complete request per record, latency counted from acceptance
    for (int i = 0; i < 5; i++) begin
      switch_req = 1'b0;
      step();
      switch_sel = vecs[i].sel;
      switch_req = 1'b1;
      wait_ack(200, lat);
      chk("vec_lat",  32'(lat),        32'(vecs[i].lat));
      chk("vec_en",   32'(vco_clk_en), 32'(vecs[i].en));
      chk("vec_vrst", 32'(vco_reset),  32'(vecs[i].rst));
      chk("vec_asel", 32'(active_sel), 32'(vecs[i].asel));
      chk("vec_vld",  32'(active_vld), 32'(vecs[i].vld));
      chk("vec_err",  32'(switch_err), 32'(vecs[i].err));
      switch_req = 1'b0;
      step();
      chk("vec_idle_busy", 32'(busy), 32'h0);
    end

    // Cycle-by-cycle profile of a 0 -> 1 switch
    switch_sel = 2'd1;
    switch_req = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      step();
      switch_req = 1'b0;
      e_rst = (c <= 8) ? 3'b110 : ((c <= 24) ? 3'b111 : 3'b101);
      e_en  = (c >= 26) ? 3'b010 : 3'b000;
      chk("seq_en",   32'(vco_clk_en), 32'(e_en));
      chk("seq_vrst", 32'(vco_reset),  32'(e_rst));
      chk("seq_ack",  32'(switch_ack), (c == 26) ? 32'h1 : 32'h0);
      chk("seq_busy", 32'(busy),       (c <= 26) ? 32'h1 : 32'h0);
      chk("seq_vld",  32'(active_vld), (c >= 26) ? 32'h1 : 32'h0);
    end

    // Request held high through ack yields one sequence only
    switch_sel = 2'd2;
    switch_req = 1'b1;
    wait_ack(100, lat);
    chk("hold_lat", 32'(lat), 32'd26);
    acks = 0;
    busy_seen = 0;
    repeat (40) begin
      step();
      if (switch_ack) acks++;
      if (busy) busy_seen++;
    end
    chk("hold_acks", 32'(acks),       32'd0);
    chk("hold_busy", 32'(busy_seen),  32'd0);
    chk("hold_en",   32'(vco_clk_en), 32'h4);
    switch_req = 1'b0;
    step();

    // Lock drop on the active channel while idle
    vco_lock = 3'b011;
    step();
    chk("lost_set", 32'(lock_lost), 32'h1);
    chk("lost_en",  32'(vco_clk_en), 32'h4);
    vco_lock = 3'b111;
    repeat (3) step();
    chk("lost_sticky", 32'(lock_lost), 32'h1);
    switch_sel = 2'd2;
    switch_req = 1'b1;
    step();
    chk("lost_clr_ack", 32'(switch_ack), 32'h1);
    chk("lost_clr",     32'(lock_lost),  32'h0);
    chk("lost_clr_err", 32'(switch_err), 32'h0);
    switch_req = 1'b0;
    step();

    // Reset asserted in the middle of RST
    switch_sel = 2'd0;
    switch_req = 1'b1;
    repeat (12) step();
    chk("mid_busy", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_en",   32'(vco_clk_en), 32'h0);
    chk("mid_vrst", 32'(vco_reset),  32'h7);
    chk("mid_asel", 32'(active_sel), 32'h0);
    chk("mid_vld",  32'(active_vld), 32'h0);
    chk("mid_busyr",32'(busy),       32'h0);
    chk("mid_ack",  32'(switch_ack), 32'h0);
    repeat (2) step();
    reset_n = 1'b1;
    acks = 0;
    busy_seen = 0;
    repeat (30) begin
      step();
      if (switch_ack) acks++;
      if (busy) busy_seen++;
    end
    chk("post_rst_acks", 32'(acks),      32'd0);
    chk("post_rst_busy", 32'(busy_seen), 32'd0);
    switch_req = 1'b0;
    step();

    // Lock never arrives on the target channel
    vco_lock   = 3'b011;
    switch_sel = 2'd2;
    switch_req = 1'b1;
`ifdef MVP_PLL_VCO_SEQ_TIMEOUT_EN
    wait_ack(200, lat);
    chk("to_lat",  32'(lat),        32'd49);
    chk("to_err",  32'(switch_err), 32'h1);
    chk("to_vrst", 32'(vco_reset),  32'h7);
    chk("to_vld",  32'(active_vld), 32'h0);
    chk("to_en",   32'(vco_clk_en), 32'h0);
    switch_req = 1'b0;
    step();
    chk("to_busy", 32'(busy), 32'h0);
`else
    wait_ack(100, lat);
    chk("nto_noack", 32'(lat),  32'hFFFF_FFFF);
    chk("nto_busy",  32'(busy), 32'h1);
    vco_lock = 3'b111;
    wait_ack(5, lat);
    chk("nto_lat", 32'(lat),        32'd1);
    chk("nto_err", 32'(switch_err), 32'h0);
    chk("nto_en",  32'(vco_clk_en), 32'h4);
    switch_req = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
